// File: rtl/sar_search_8_bits_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_8_bits_pkg
//  Description : Shared definitions for the successive-approximation search:
//                state encodings, settle counter width and a one-hot check
//                for comparator eq/gt/lt flag triples.
//  Revision    : 1.0 - initial release
// ============================================================================
package sar_search_8_bits_pkg;

    // FSM state encodings
    localparam logic [1:0] SAR_IDLE   = 2'd0;
    localparam logic [1:0] SAR_TRY    = 2'd1;
    localparam logic [1:0] SAR_VERIFY = 2'd2;
    localparam logic [1:0] SAR_DONE   = 2'd3;

    // Settle counter width: SETTLE ranges 0..15
    localparam int SETTLE_W = 4;

    // True when exactly one of the three comparator flags is set
    function automatic logic onehot3(input logic eq, input logic gt, input logic lt);
        return ({eq, gt, lt} == 3'b100) ||
               ({eq, gt, lt} == 3'b010) ||
               ({eq, gt, lt} == 3'b001);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_search_8_bits_settle.sv
`default_nettype none
// ============================================================================
//  Module      : sar_settle_timer
//  Description : Loadable down-counter that spaces comparator samples.
//                load reloads SETTLE, tick counts down to zero and stops.
//                With SETTLE=0 the count never leaves zero, so zero is
//                permanently true.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_settle_timer
    import sar_search_8_bits_pkg::*;
#(
    parameter int SETTLE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic zero
);

    localparam logic [SETTLE_W-1:0] c_load = SETTLE_W'(SETTLE);

    logic [SETTLE_W-1:0] r_count;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_load;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - SETTLE_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sar_search_8_bits.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_8_bits
//  Description : Successive-approximation search engine. Drives a trial word
//                onto an external comparator and resolves the target MSB-first
//                from the one-hot eq/gt/lt flags, reporting result/found/err.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_search_8_bits
    import sar_search_8_bits_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int               IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] c_idx_max = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_msb     = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_trial;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_found;
    logic             r_err;

    logic             w_zero;
    logic             w_in_slot;
    logic             w_sample;
    logic             w_load;
    logic             w_tick;
    logic             w_onehot;
    logic [IDX_W-1:0] w_idx_dn;

    // A sample edge is the first edge of a compare slot with the settle count expired
    assign w_in_slot = (r_state == SAR_TRY) || (r_state == SAR_VERIFY);
    assign w_sample  = w_in_slot && w_zero;
    assign w_load    = ((r_state == SAR_IDLE) && start) || w_sample;
    assign w_tick    = w_in_slot && !w_zero;
    assign w_onehot  = onehot3(cmp_eq, cmp_gt, cmp_lt);
    assign w_idx_dn  = r_idx - IDX_W'(1);

    sar_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .tick  (w_tick),
        .zero  (w_zero)
    );

    // Search FSM: trial bit decisions, result capture and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SAR_IDLE;
            r_idx    <= c_idx_max;
            r_trial  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                SAR_IDLE: begin
                    if (start) begin
                        r_trial <= c_msb;
                        r_idx   <= c_idx_max;
                        r_found <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SAR_TRY;
                    end
                end
                SAR_TRY: begin
                    if (w_sample) begin
                        if (!w_onehot) begin
                            r_err    <= 1'b1;
                            r_found  <= 1'b0;
                            r_result <= r_trial;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= SAR_DONE;
                        end else if (cmp_eq) begin
                            // Exact hit: the remaining bits need no resolving
                            r_result <= r_trial;
                            r_found  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= SAR_DONE;
                        end else begin
                            // gt keeps the bit under test, lt clears it
                            r_trial[r_idx] <= cmp_gt;
                            if (r_idx != '0) begin
                                r_trial[w_idx_dn] <= 1'b1;
                                r_idx             <= w_idx_dn;
                            end else begin
                                r_state <= SAR_VERIFY;
                            end
                        end
                    end
                end
                SAR_VERIFY: begin
                    if (w_sample) begin
                        r_result <= r_trial;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= SAR_DONE;
                        if (!w_onehot) begin
                            r_err   <= 1'b1;
                            r_found <= 1'b0;
                        end else begin
                            r_found <= cmp_eq;
                        end
                    end
                end
                SAR_DONE: begin
                    r_state <= SAR_IDLE;
                end
                default: begin
                    r_state <= SAR_IDLE;
                end
            endcase
        end
    end

    assign trial  = r_trial;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign found  = r_found;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sar_search_8_bits.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_search_8_bits
//  Description : Bench for sar_search_8_bits. Two instances (SETTLE=0 and
//                SETTLE=3) each drive a behavioural 8-bit comparator. Directed
//                searches push hand-computed results into per-instance queues
//                that monitors pop on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search_8_bits;

    typedef struct {
        logic [7:0] result;
        logic       found;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start0 = 1'b0, start3 = 1'b0;
    logic [7:0] target0 = 8'h00, target3 = 8'h00;
    logic       force0 = 1'b0;

    logic       eq0, gt0, lt0, eq3, gt3, lt3;
    logic [7:0] trial0, result0, trial3, result3;
    logic       busy0, done0, found0, err0;
    logic       busy3, done3, found3, err3;

    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         st0 = 0, st3 = 0;
    logic       pbusy0 = 1'b0, pbusy3 = 1'b0;

    exp_t       q0[$];
    exp_t       q3[$];
    logic [7:0] tq0[$];
    exp_t       e0, e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural comparators: A = target, B = trial; force0 injects gt=lt=1
    assign eq0 = force0 ? 1'b0 : (target0 == trial0);
    assign gt0 = force0 ? 1'b1 : (target0 >  trial0);
    assign lt0 = force0 ? 1'b1 : (target0 <  trial0);
    assign eq3 = (target3 == trial3);
    assign gt3 = (target3 >  trial3);
    assign lt3 = (target3 <  trial3);

    sar_search_8_bits #(.WIDTH(8), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .cmp_eq(eq0), .cmp_gt(gt0), .cmp_lt(lt0),
        .trial(trial0), .busy(busy0), .done(done0),
        .result(result0), .found(found0), .err(err0)
    );

    sar_search_8_bits #(.WIDTH(8), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .cmp_eq(eq3), .cmp_gt(gt3), .cmp_lt(lt3),
        .trial(trial3), .busy(busy3), .done(done3),
        .result(result3), .found(found3), .err(err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the SETTLE=0 instance: trial sequence and done results
    always @(negedge clk) begin
        if (busy0 && !pbusy0) st0 = cyc;
        pbusy0 = busy0;
        if (busy0 && tq0.size() > 0) chk("trial0", trial0, tq0.pop_front());
        if (done0) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", 1, 0);
            end else begin
                e0 = q0.pop_front();
                chk("result0", result0, e0.result);
                chk("found0", found0, e0.found);
                chk("err0", err0, e0.err);
                chk("latency0", cyc - st0, e0.lat);
                chk("busy0_at_done", busy0, 0);
            end
        end
    end

    // Monitor for the SETTLE=3 instance
    always @(negedge clk) begin
        if (busy3 && !pbusy3) st3 = cyc;
        pbusy3 = busy3;
        if (done3) begin
            if (q3.size() == 0) begin
                chk("unexpected_done3", 1, 0);
            end else begin
                e3 = q3.pop_front();
                chk("result3", result3, e3.result);
                chk("found3", found3, e3.found);
                chk("err3", err3, e3.err);
                chk("latency3", cyc - st3, e3.lat);
            end
        end
    end

    task automatic push0(input logic [7:0] r, input logic f, input logic e, input int l);
        exp_t x;
        x.result = r; x.found = f; x.err = e; x.lat = l;
        q0.push_back(x);
    endtask

    task automatic push3(input logic [7:0] r, input logic f, input logic e, input int l);
        exp_t x;
        x.result = r; x.found = f; x.err = e; x.lat = l;
        q3.push_back(x);
    endtask

    // Present start for one edge; returns #1 after the accept edge
    task automatic start_search(input int id, input logic [7:0] t);
        @(negedge clk);
        if (id == 0) begin target0 = t; start0 = 1'b1; end
        else         begin target3 = t; start3 = 1'b1; end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start3 = 1'b0;
    endtask

    // Wait for done with a cycle budget; counts busy gaps before done
    task automatic wait_done(input int id, input int budget, output int gaps);
        int  n;
        logic seen;
        gaps = 0;
        seen = 1'b0;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((id == 0) ? done0 : done3) begin
                seen = 1'b1;
                break;
            end
            if (!((id == 0) ? busy0 : busy3)) gaps++;
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic check_zero0(input string tag);
        chk({tag, "_trial"},  trial0,  0);
        chk({tag, "_busy"},   busy0,   0);
        chk({tag, "_done"},   done0,   0);
        chk({tag, "_result"}, result0, 0);
        chk({tag, "_found"},  found0,  0);
        chk({tag, "_err"},    err0,    0);
    endtask

    initial begin
        int gaps;
        logic [7:0] seq55 [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h54, 8'h56, 8'h55};
        logic [7:0] seq00 [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero0("reset");
        chk("reset_trial3", trial3, 0);
        chk("reset_busy3",  busy3,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // target 0x55: eq on the 8th sample
        foreach (seq55[i]) tq0.push_back(seq55[i]);
        push0(8'h55, 1'b1, 1'b0, 8);
        start_search(0, 8'h55);
        wait_done(0, 40, gaps);

        // target 0x80: eq on the 1st sample
        push0(8'h80, 1'b1, 1'b0, 1);
        start_search(0, 8'h80);
        wait_done(0, 40, gaps);

        // target 0x00: worst-case latency, resolved at VERIFY
        foreach (seq00[i]) tq0.push_back(seq00[i]);
        push0(8'h00, 1'b1, 1'b0, 9);
        start_search(0, 8'h00);
        wait_done(0, 40, gaps);

        // target 0x3C: 80,40,20,30,38,3C -> eq on the 6th sample
        push0(8'h3C, 1'b1, 1'b0, 6);
        start_search(0, 8'h3C);
        wait_done(0, 40, gaps);

        // Fault: gt=lt=1 on the 3rd sample while trial=0x60
        push0(8'h60, 1'b0, 1'b1, 3);
        start_search(0, 8'h55);
        @(posedge clk);
        @(posedge clk);
        #1 force0 = 1'b1;
        @(posedge clk);
        #1 force0 = 1'b0;
        wait_done(0, 40, gaps);

        // Reset during the 4th slot: outputs clear at once, no done
        start_search(0, 8'h55);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_zero0("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // New search after reset completes normally
        push0(8'h55, 1'b1, 1'b0, 8);
        start_search(0, 8'h55);
        wait_done(0, 40, gaps);

        // SETTLE=3, target 0xFF: 4-cycle slots, mid-search start ignored
        push3(8'hFF, 1'b1, 1'b0, 32);
        start_search(3, 8'hFF);
        repeat (10) @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_done(3, 60, gaps);
        chk("busy3_continuous_gaps", gaps, 0);

        // SETTLE=3, target 0x00: 9 slots of 4 cycles
        push3(8'h00, 1'b1, 1'b0, 36);
        start_search(3, 8'h00);
        wait_done(3, 60, gaps);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q3_drained", q3.size(), 0);
        chk("tq0_drained", tq0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
